// File: rtl/hci_core_memmap_demux_outstanding_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_memmap_demux_outstanding_pkg
// Purpose  : Shared defaults and helpers for the memory-mapped HCI demux
//            family (address/data widths, error data pattern, target index
//            width helper, error data replication).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hci_core_memmap_demux_outstanding_pkg;

   localparam int unsigned DEFAULT_AW = 32;
   localparam int unsigned DEFAULT_DW = 32;

   // Data word returned for accesses that hit no region.
   localparam logic [31:0] HCI_DEMUX_ERR_DATA = 32'hBADCAB1E;

   // Widest data bus the error pattern can be replicated onto.
   localparam int unsigned MAX_ERR_DW = 1024;

   typedef logic [MAX_ERR_DW-1:0] err_fill_t;

   // Width of a target index: NB_REGION real targets plus the internal
   // error target sitting at index NB_REGION.
   function automatic int unsigned demux_target_w(input int unsigned nb_region);
      return $clog2(nb_region + 1);
   endfunction

   // Replicates the 32-bit error pattern across the widest supported bus;
   // callers truncate to their own DW.
   function automatic err_fill_t err_data_fill(input logic [31:0] d);
      return {(MAX_ERR_DW / 32){d}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hci_core_memmap_demux_outstanding_if.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_intf
// Purpose  : HCI core request/response bundle.
// Ports    : req/gnt handshake, add, wen, data, be, boffs, lrdy (request),
//            r_data, r_valid, r_opc (response).
//            master modport drives requests; slave modport answers them.
// Revision : 1.0 - initial release
// ============================================================================
interface hci_core_intf #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32
) ();
   logic              req;
   logic              gnt;
   logic [AW-1:0]     add;
   logic              wen;
   logic [DW-1:0]     data;
   logic [DW/8-1:0]   be;
   logic [15:0]       boffs;
   logic              lrdy;
   logic [DW-1:0]     r_data;
   logic              r_valid;
   logic              r_opc;

   modport master (
      output req, add, wen, data, be, boffs, lrdy,
      input  gnt, r_data, r_valid, r_opc
   );

   modport slave (
      input  req, add, wen, data, be, boffs, lrdy,
      output gnt, r_data, r_valid, r_opc
   );
endinterface
`default_nettype wire

// File: rtl/hci_core_memmap_demux_outstanding_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_memmap_decoder
// Purpose  : Combinational priority address decoder. A region matches when
//            start <= addr < end; the lowest matching index wins. No match
//            returns index NB_REGION with hit_o low.
// Ports    : addr_i        address to decode
//            start_addr_i  inclusive start per region
//            end_addr_i    exclusive end per region
//            target_o      selected target index
//            hit_o         high when some region matched
// Revision : 1.0 - initial release
// ============================================================================
module hci_core_memmap_decoder
   import hci_core_memmap_demux_outstanding_pkg::*;
#(
   parameter int unsigned NB_REGION = 2,
   parameter int unsigned AW        = DEFAULT_AW
) (
   input  logic [AW-1:0]                          addr_i,
   input  logic [NB_REGION-1:0][AW-1:0]           start_addr_i,
   input  logic [NB_REGION-1:0][AW-1:0]           end_addr_i,
   output logic [demux_target_w(NB_REGION)-1:0]   target_o,
   output logic                                   hit_o
);
   localparam int unsigned c_tw = demux_target_w(NB_REGION);

   // Scan from the highest index down so the lowest match is written last.
   always_comb begin
      target_o = c_tw'(NB_REGION);
      hit_o    = 1'b0;
      for (int i = int'(NB_REGION) - 1; i >= 0; i--) begin
         if ((addr_i >= start_addr_i[i]) && (addr_i < end_addr_i[i])) begin
            target_o = c_tw'(i);
            hit_o    = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/hci_core_memmap_demux_outstanding.sv
`default_nettype none
// ============================================================================
// Module   : hci_core_memmap_demux_outstanding
// Purpose  : Address-decoding demux from one HCI initiator to NB_REGION
//            targets with up to MAX_OUTSTANDING pipelined requests, in-order
//            responses, and an internal error target for unmapped addresses.
// Ports    : clk_i, rst_ni (sync, active-low), clear_i (sync soft clear)
//            region_start_addr_i / region_end_addr_i  region map
//            slave      initiator-side HCI port
//            master[]   target-side HCI ports
//            err_o      pulses with each error response
// Revision : 1.0 - initial release
// ============================================================================
module hci_core_memmap_demux_outstanding
   import hci_core_memmap_demux_outstanding_pkg::*;
#(
   parameter int unsigned NB_REGION       = 2,
   parameter int unsigned AW              = DEFAULT_AW,
   parameter int unsigned AWC             = DEFAULT_AW,
   parameter int unsigned DW              = DEFAULT_DW,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [31:0] ERR_DATA        = HCI_DEMUX_ERR_DATA
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic [NB_REGION-1:0][AW-1:0]  region_start_addr_i,
   input  logic [NB_REGION-1:0][AW-1:0]  region_end_addr_i,
   hci_core_intf.slave                   slave,
   hci_core_intf.master                  master [NB_REGION],
   output logic                          err_o
);
   localparam int unsigned      c_tw       = demux_target_w(NB_REGION);
   localparam int unsigned      c_nt       = 1 << c_tw;
   localparam int unsigned      c_cw       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_tw-1:0]  c_err_tgt  = c_tw'(NB_REGION);
   localparam logic [c_cw-1:0]  c_max_cnt  = c_cw'(MAX_OUTSTANDING);
   localparam logic [DW-1:0]    c_err_data = DW'(err_data_fill(ERR_DATA));

   logic [c_cw-1:0]  r_cnt;
   logic [c_tw-1:0]  r_lock;
   logic             r_err_pend;

   logic [c_tw-1:0]  w_tgt;
   logic             w_hit;
   logic             w_busy;
   logic             w_rsp_valid;
   logic             w_last_ret;
   logic             w_switch;
   logic             w_stall;
   logic             w_fwd;
   logic             w_hs;

   // Per-target views indexed by target number; entry NB_REGION is the
   // internal error target, higher entries are unused padding.
   logic             w_rv_arr  [c_nt];
   logic             w_gnt_arr [c_nt];
   logic             w_ro_arr  [c_nt];
   logic [DW-1:0]    w_rd_arr  [c_nt];

   hci_core_memmap_decoder #(
      .NB_REGION (NB_REGION),
      .AW        (AW)
   ) u_decoder (
      .addr_i       (slave.add),
      .start_addr_i (region_start_addr_i),
      .end_addr_i   (region_end_addr_i),
      .target_o     (w_tgt),
      .hit_o        (w_hit)
   );

   for (genvar k = 0; k < c_nt; k++) begin : g_rsp
      if (k < NB_REGION) begin : g_tgt
         assign w_rv_arr[k]  = master[k].r_valid;
         assign w_gnt_arr[k] = master[k].gnt;
         assign w_ro_arr[k]  = master[k].r_opc;
         assign w_rd_arr[k]  = master[k].r_data;
      end else if (k == NB_REGION) begin : g_err
         assign w_rv_arr[k]  = r_err_pend;
         assign w_gnt_arr[k] = 1'b1;
         assign w_ro_arr[k]  = 1'b1;
         assign w_rd_arr[k]  = c_err_data;
      end else begin : g_pad
         assign w_rv_arr[k]  = 1'b0;
         assign w_gnt_arr[k] = 1'b0;
         assign w_ro_arr[k]  = 1'b0;
         assign w_rd_arr[k]  = '0;
      end
   end

   // Responses are only accepted from the locked target while something is
   // outstanding; anything a target returns while idle is dropped.
   assign w_busy      = (r_cnt != '0);
   assign w_rsp_valid = w_busy & w_rv_arr[r_lock];
   assign w_last_ret  = (r_cnt == c_cw'(1)) & w_rsp_valid;

   // A request to a different target waits until the final outstanding
   // response is on the bus, so ordering across targets is preserved.
   assign w_switch = w_busy & (w_tgt != r_lock) & ~w_last_ret;
   assign w_stall  = slave.req & (w_switch | ((r_cnt == c_max_cnt) & ~w_rsp_valid));
   assign w_fwd    = slave.req & ~w_stall & rst_ni & ~clear_i;
   assign w_hs     = w_fwd & w_gnt_arr[w_tgt];

   assign slave.gnt     = w_hs;
   assign slave.r_valid = w_rsp_valid;
   assign slave.r_data  = w_busy ? w_rd_arr[r_lock] : '0;
   assign slave.r_opc   = w_busy & w_ro_arr[r_lock];
   assign err_o         = w_rsp_valid & (r_lock == c_err_tgt);

   for (genvar i = 0; i < NB_REGION; i++) begin : g_master
      localparam logic [c_tw-1:0] c_idx = c_tw'(i);
      logic [AWC-1:0] w_off;

      // Region-relative address, wrapping within the target address space.
      assign w_off = slave.add[AWC-1:0] - region_start_addr_i[i][AWC-1:0];

      assign master[i].req   = w_fwd & (w_tgt == c_idx);
      assign master[i].add   = AW'(w_off);
      assign master[i].wen   = slave.wen;
      assign master[i].data  = slave.data;
      assign master[i].be    = slave.be;
      assign master[i].boffs = slave.boffs;
      assign master[i].lrdy  = slave.lrdy;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_cnt      <= '0;
         r_lock     <= '0;
         r_err_pend <= 1'b0;
      end else begin
         if (w_hs && !w_rsp_valid) begin
            r_cnt <= r_cnt + c_cw'(1);
         end else if (!w_hs && w_rsp_valid) begin
            r_cnt <= r_cnt - c_cw'(1);
         end
         if (w_hs) begin
            r_lock <= w_tgt;
         end
         // The error target answers exactly one cycle after its grant.
         r_err_pend <= w_hs & ~w_hit;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_hci_core_memmap_demux_outstanding.sv
`default_nettype none
// ============================================================================
// Module   : tb_hci_core_memmap_demux_outstanding
// Purpose  : Scoreboard bench for the outstanding memmap demux: directed
//            scenarios plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_core_memmap_demux_outstanding;
   localparam int unsigned NB   = 2;
   localparam int unsigned MAXO = 3;
   localparam logic [31:0] ERRD = 32'hBADCAB1E;

   typedef struct { logic [31:0] data; logic opc; logic err; int due; } exp_t;
   typedef struct { logic [31:0] d; int due; } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic err;
   logic [NB-1:0][31:0] rs;
   logic [NB-1:0][31:0] re;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int lat [NB];
   int last_gcyc;
   int last_wait;
   exp_t sb[$];

   logic        m_req [NB];
   logic [31:0] m_add [NB];

   hci_core_intf #(.DW(32), .AW(32)) slv ();
   hci_core_intf #(.DW(32), .AW(32)) mst [NB] ();

   hci_core_memmap_demux_outstanding #(
      .NB_REGION       (NB),
      .AW              (32),
      .AWC             (16),
      .DW              (32),
      .MAX_OUTSTANDING (MAXO),
      .ERR_DATA        (ERRD)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .clear_i             (clear),
      .region_start_addr_i (rs),
      .region_end_addr_i   (re),
      .slave               (slv),
      .master              (mst),
      .err_o               (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference decode: first region (lowest index) whose [start,end) holds a.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < int'(NB); i++)
         if (a >= rs[i] && a < re[i]) return i;
      return -1;
   endfunction

   function automatic exp_t ref_resp(input logic [31:0] a, input int gcyc);
      exp_t e;
      int t = ref_decode(a);
      if (t < 0) begin
         e = '{ERRD, 1'b1, 1'b1, gcyc + 1};
      end else begin
         e.data = 32'hA000_0000 | (32'(t) << 16) | ((a - rs[t]) & 32'h0000_FFFF);
         e.opc  = 1'b0;
         e.err  = 1'b0;
         e.due  = gcyc + lat[t];
      end
      return e;
   endfunction

   // Behavioural targets: always grant, answer with data derived from the
   // translated address after a fixed per-target latency.
   for (genvar g = 0; g < NB; g++) begin : g_tgt
      rsp_t q[$];
      assign m_req[g] = mst[g].req;
      assign m_add[g] = mst[g].add;
      initial begin
         mst[g].gnt     = 1'b1;
         mst[g].r_valid = 1'b0;
         mst[g].r_data  = '0;
         mst[g].r_opc   = 1'b0;
         forever begin
            @(negedge clk);
            if (mst[g].req && mst[g].gnt) begin
               check("add_hi", {16'h0, mst[g].add[31:16]}, 32'h0);
               q.push_back('{32'hA000_0000 | (32'(g) << 16) | {16'h0, mst[g].add[15:0]},
                             cyc + lat[g]});
            end
            @(posedge clk);
            #1;
            mst[g].r_valid = 1'b0;
            mst[g].r_data  = '0;
            if (q.size() > 0 && q[0].due <= cyc) begin
               mst[g].r_valid = 1'b1;
               mst[g].r_data  = q.pop_front().d;
            end
         end
      end
   end

   // Monitor: every response the DUT presents is matched against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && !clear) begin
            if (slv.r_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rvalid: got r_data %h with empty scoreboard (cycle %0d)",
                           slv.r_data, cyc);
               end else begin
                  e = sb.pop_front();
                  check("r_data", slv.r_data, e.data);
                  check("r_opc", {31'h0, slv.r_opc}, {31'h0, e.opc});
                  check("err_o", {31'h0, err}, {31'h0, e.err});
                  check("r_cycle", cyc, e.due);
               end
            end else begin
               check("err_o_idle", {31'h0, err}, 32'h0);
            end
         end
      end
   end

   // Drives one request; call at posedge+1, returns at posedge+1 after grant.
   task automatic issue(input logic [31:0] a);
      int w = 0;
      bit done = 1'b0;
      int t;
      logic [31:0] exp_req;
      slv.req  = 1'b1;
      slv.add  = a;
      slv.wen  = 1'b1;
      slv.data = $urandom;
      slv.be   = 4'hF;
      while (!done) begin
         @(negedge clk);
         t = ref_decode(a);
         if (slv.gnt) begin
            exp_req = (t < 0) ? 32'h0 : (32'h1 << t);
            check("m_req_fwd", {30'h0, m_req[1], m_req[0]}, exp_req);
            if (t >= 0) check("m_add", m_add[t], (a - rs[t]) & 32'h0000_FFFF);
            sb.push_back(ref_resp(a, cyc));
            last_gcyc = cyc;
            last_wait = w;
            done = 1'b1;
         end else begin
            check("stall_m_req", {30'h0, m_req[1], m_req[0]}, 32'h0);
            w++;
            if (w > 40) begin
               checks++;
               errors++;
               $display("FAIL grant_timeout: got no gnt expected gnt for addr %h", a);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      slv.req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_empty", sb.size(), 32'h0);
      idle(2);
   endtask

   task automatic set_map(input logic [31:0] s0, input logic [31:0] e0,
                          input logic [31:0] s1, input logic [31:0] e1);
      rs[0] = s0; re[0] = e0; rs[1] = s1; re[1] = e1;
   endtask

   initial begin
      int g0;
      int gc [4];
      logic [31:0] a;
      int r;
      lat[0] = 1;
      lat[1] = 1;
      set_map(32'h0, 32'h1000, 32'h1000, 32'h2000);
      slv.req = 1'b1; slv.add = 32'h10; slv.wen = 1'b1; slv.data = '0;
      slv.be = '0; slv.boffs = '0; slv.lrdy = 1'b1;

      // Reset: no forwarding while rst_n is low, quiet outputs afterwards.
      @(negedge clk);
      check("rst_gnt", {31'h0, slv.gnt}, 32'h0);
      check("rst_m_req", {30'h0, m_req[1], m_req[0]}, 32'h0);
      @(posedge clk);
      #1;
      slv.req = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rvalid", {31'h0, slv.r_valid}, 32'h0);
      check("rst_rdata", slv.r_data, 32'h0);
      check("rst_ropc", {31'h0, slv.r_opc}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      @(posedge clk);
      #1;

      // Back-to-back reads, 1-cycle target: one grant per cycle.
      for (int k = 0; k < 4; k++) begin
         issue(32'h10 + 32'(4 * k));
         gc[k] = last_gcyc;
         if (k > 0) check("b2b_gap", gc[k] - gc[k-1], 32'd1);
      end
      drain();

      // Outstanding limit: fourth request waits for the first response.
      lat[0] = 5;
      for (int k = 0; k < 4; k++) begin
         issue(32'h100 + 32'(4 * k));
         gc[k] = last_gcyc;
      end
      check("max_stall_grant", gc[3] - gc[0], 32'd5);
      drain();

      // Region switch: second target granted when region 0 answers.
      lat[0] = 3;
      issue(32'h40);
      g0 = last_gcyc;
      issue(32'h1040);
      check("switch_grant", last_gcyc - g0, 32'd3);
      drain();

      // Unmapped accesses: immediate grant, 1-cycle error response.
      issue(32'h3000);
      check("err_wait", last_wait, 32'd0);
      g0 = last_gcyc;
      issue(32'h4000);
      check("err_b2b_gap", last_gcyc - g0, 32'd1);
      drain();

      // Overlapping regions: lowest index wins.
      set_map(32'h0, 32'h2000, 32'h1000, 32'h3000);
      issue(32'h1800);
      drain();
      set_map(32'h0, 32'h1000, 32'h1000, 32'h2000);

      // Reset with three outstanding: state dropped, stale data ignored.
      lat[0] = 5;
      for (int k = 0; k < 3; k++) issue(32'h200 + 32'(4 * k));
      rst_n = 1'b0;
      sb.delete();
      slv.req = 1'b1;
      slv.add = 32'h1100;
      @(negedge clk);
      check("midrst_gnt", {31'h0, slv.gnt}, 32'h0);
      check("midrst_m_req", {30'h0, m_req[1], m_req[0]}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(32'h1100);
      check("post_rst_wait", last_wait, 32'd0);
      drain();
      idle(8);

      // Soft clear behaves like reset.
      for (int k = 0; k < 2; k++) issue(32'h300 + 32'(4 * k));
      clear = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      clear = 1'b0;
      issue(32'h5000);
      check("post_clr_wait", last_wait, 32'd0);
      drain();
      idle(8);

      // Randomized mixed traffic.
      lat[0] = 2;
      lat[1] = 3;
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 2));
         if (r == 0)      a = $urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC;
         else if (r == 1) a = 32'h1000 + ($urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC);
         else             a = 32'h2000 + ($urandom_range(0, 32'hDFFF) & 32'hFFFF_FFFC);
         issue(a);
         idle(int'($urandom_range(0, 2)));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
